// File: rtl/me_plane_ctrl_pkg.sv
// me_plane_ctrl_pkg: shared widths, bullet modes and plane-control defaults
package me_plane_ctrl_pkg;
    localparam int OBJ_X_POS_BIT_LEN = 10;
    localparam int OBJ_Y_POS_BIT_LEN = 10;
    localparam logic BULLET_MODE_SINGLE = 1'b0;
    localparam logic BULLET_MODE_DOUBLE = 1'b1;
    localparam int ME_START_X = 269;
    localparam int ME_START_Y = 340;
    localparam int ME_STEP = 2;
    localparam int CNT_MAX_MOVE = 2_000_000;
    localparam int DOUBLE_TICKS = 1250;
    typedef enum logic {
        MODE_SINGLE = BULLET_MODE_SINGLE,
        MODE_DOUBLE = BULLET_MODE_DOUBLE
    } mode_e;
endpackage

// File: rtl/me_plane_ctrl_axis_step.sv
// me_plane_ctrl_axis_step: next position on one axis, clamped to [0, MAX]
module me_plane_ctrl_axis_step #(
    parameter int W    = 10,
    parameter int MAX  = 538,
    parameter int STEP = 2
) (
    input  logic [W-1:0] pos,
    input  logic         dec,
    input  logic         inc,
    input  logic         tick,
    output logic [W-1:0] next_pos
);
    logic [W:0] sum;
    // compare before subtracting so the low side never wraps; add in W+1 bits
    always_comb begin
        sum = {1'b0, pos} + (W+1)'(STEP);
        next_pos = pos;
        if (tick && dec && !inc)
            next_pos = (pos < W'(STEP)) ? '0 : pos - W'(STEP);
        else if (tick && inc && !dec)
            next_pos = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
    end
endmodule

// File: rtl/me_plane_ctrl.sv
// me_plane_ctrl: button-driven player position with clamping and power-up fire mode
module me_plane_ctrl
    import me_plane_ctrl_pkg::*;
#(
    parameter int H_DISP       = 640,
    parameter int V_DISP       = 480,
    parameter int PLANE_W      = 102,
    parameter int PLANE_H      = 126,
    parameter int START_X      = me_plane_ctrl_pkg::ME_START_X,
    parameter int START_Y      = me_plane_ctrl_pkg::ME_START_Y,
    parameter int STEP         = me_plane_ctrl_pkg::ME_STEP,
    parameter int MOVE_DIV     = me_plane_ctrl_pkg::CNT_MAX_MOVE,
    parameter int DOUBLE_TICKS = me_plane_ctrl_pkg::DOUBLE_TICKS
) (
    input  logic                         clk_run,
    input  logic                         rst,
    input  logic                         btn_up_i,
    input  logic                         btn_down_i,
    input  logic                         btn_left_i,
    input  logic                         btn_right_i,
    input  logic                         game_en_i,
    input  logic                         powerup_i,
    input  logic                         hit_i,
    output logic [OBJ_X_POS_BIT_LEN-1:0] me_x_pos_o,
    output logic [OBJ_Y_POS_BIT_LEN-1:0] me_y_pos_o,
    output logic                         mode_o,
    output logic                         move_tick_o
);
    localparam int DIV_W = $clog2(MOVE_DIV);
    localparam int DBL_W = $clog2(DOUBLE_TICKS + 1);
    logic [3:0] btn_meta, btn_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [DBL_W-1:0] dbl_cnt, dbl_cnt_nxt;
    mode_e state, state_nxt;
    logic tick;
    logic [OBJ_X_POS_BIT_LEN-1:0] x_nxt;
    logic [OBJ_Y_POS_BIT_LEN-1:0] y_nxt;
    assign tick = game_en_i && (div_cnt == DIV_W'(MOVE_DIV - 1));
    assign mode_o = state;
    // two-flop synchronizer for the button levels, ordered {up, down, left, right}
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
            btn_sync <= btn_meta;
        end
    end
    // move-tick divider; holds while the game is frozen
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            move_tick_o <= 1'b0;
        end else begin
            move_tick_o <= tick;
            if (game_en_i) div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        end
    end
    me_plane_ctrl_axis_step #(.W(OBJ_X_POS_BIT_LEN), .MAX(H_DISP - PLANE_W), .STEP(STEP)) u_x_step (
        .pos(me_x_pos_o), .dec(btn_sync[1]), .inc(btn_sync[0]), .tick(tick), .next_pos(x_nxt)
    );
    me_plane_ctrl_axis_step #(.W(OBJ_Y_POS_BIT_LEN), .MAX(V_DISP - PLANE_H), .STEP(STEP)) u_y_step (
        .pos(me_y_pos_o), .dec(btn_sync[3]), .inc(btn_sync[2]), .tick(tick), .next_pos(y_nxt)
    );
    // position register; a hit respawns the plane ahead of any move
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            me_x_pos_o <= OBJ_X_POS_BIT_LEN'(START_X);
            me_y_pos_o <= OBJ_Y_POS_BIT_LEN'(START_Y);
        end else if (hit_i) begin
            me_x_pos_o <= OBJ_X_POS_BIT_LEN'(START_X);
            me_y_pos_o <= OBJ_Y_POS_BIT_LEN'(START_Y);
        end else begin
            me_x_pos_o <= x_nxt;
            me_y_pos_o <= y_nxt;
        end
    end
    // mode state and remaining double-mode ticks
    always_ff @(posedge clk_run or posedge rst) begin
        if (rst) begin
            state <= MODE_SINGLE;
            dbl_cnt <= '0;
        end else begin
            state <= state_nxt;
            dbl_cnt <= dbl_cnt_nxt;
        end
    end
    // hit beats power-up, power-up reload beats the expiring tick
    always_comb begin
        state_nxt = state;
        dbl_cnt_nxt = dbl_cnt;
        if (hit_i) begin
            state_nxt = MODE_SINGLE;
            dbl_cnt_nxt = '0;
        end else if (powerup_i) begin
            state_nxt = MODE_DOUBLE;
            dbl_cnt_nxt = DBL_W'(DOUBLE_TICKS);
        end else if (state == MODE_DOUBLE && tick) begin
            dbl_cnt_nxt = dbl_cnt - DBL_W'(1);
            if (dbl_cnt == DBL_W'(1)) state_nxt = MODE_SINGLE;
        end
    end
endmodule

// File: tb/tb_me_plane_ctrl.sv
// tb_me_plane_ctrl: directed vector table plus hand sequences for mode and freeze corners
module tb_me_plane_ctrl;
    logic clk_run = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic en = 1'b0, pu = 1'b0, hit = 1'b0;
    logic [9:0] x, y;
    logic mode, mt;
    int checks = 0;
    int errors = 0;
    int c;

    always #5 clk_run = ~clk_run;

    me_plane_ctrl #(.MOVE_DIV(4), .DOUBLE_TICKS(3)) dut (
        .clk_run(clk_run), .rst(rst),
        .btn_up_i(up), .btn_down_i(down), .btn_left_i(left), .btn_right_i(right),
        .game_en_i(en), .powerup_i(pu), .hit_i(hit),
        .me_x_pos_o(x), .me_y_pos_o(y), .mode_o(mode), .move_tick_o(mt)
    );

    typedef struct {
        logic [3:0] btn;
        int ticks;
        int ex;
        int ey;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk_run);
            cyc++;
        end while (!mt && cyc < 64);
        if (!mt) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual=none required=pulse");
        end
    endtask

    task automatic pulse_pu();
        pu = 1'b1;
        @(negedge clk_run);
        pu = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0000,   2, 269, 340};
        vecs[1]  = '{4'b0001,   3, 275, 340};
        vecs[2]  = '{4'b0010,   2, 271, 340};
        vecs[3]  = '{4'b1100,  10, 271, 340};
        vecs[4]  = '{4'b0010,   1, 269, 340};
        vecs[5]  = '{4'b1111,   2, 269, 340};
        vecs[6]  = '{4'b0010, 134,   1, 340};
        vecs[7]  = '{4'b0010,   1,   0, 340};
        vecs[8]  = '{4'b0010,   2,   0, 340};
        vecs[9]  = '{4'b0001, 268, 536, 340};
        vecs[10] = '{4'b0001,   1, 538, 340};
        vecs[11] = '{4'b0001,   3, 538, 340};
        vecs[12] = '{4'b0100,   7, 538, 354};
        vecs[13] = '{4'b0100,   2, 538, 354};
        vecs[14] = '{4'b1000, 177, 538,   0};
        vecs[15] = '{4'b1000,   1, 538,   0};
        vecs[16] = '{4'b0101,   1, 538,   2};

        repeat (3) @(negedge clk_run);
        chk("reset_x", int'(x), 269);
        chk("reset_y", int'(y), 340);
        chk("reset_mode", int'(mode), 0);
        chk("reset_tick", int'(mt), 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            en = 1'b0;
            {up, down, left, right} = vecs[i].btn;
            repeat (3) @(negedge clk_run);
            en = 1'b1;
            for (int t = 0; t < vecs[i].ticks; t++) wait_tick(c);
            chk($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
            chk($sformatf("vec%0d_y", i), int'(y), vecs[i].ey);
        end
        chk("table_mode", int'(mode), 0);
        {up, down, left, right} = 4'b0000;

        pulse_pu();
        chk("pre_reset_mode", int'(mode), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_x", int'(x), 269);
        chk("midrst_y", int'(y), 340);
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_tick", int'(mt), 0);
        @(negedge clk_run);
        rst = 1'b0;
        wait_tick(c);
        chk("first_tick_latency", c, 4);

        pulse_pu();
        chk("pu_mode", int'(mode), 1);
        wait_tick(c);
        chk("pu_tick1_mode", int'(mode), 1);
        wait_tick(c);
        chk("pu_tick2_mode", int'(mode), 1);
        wait_tick(c);
        chk("pu_tick3_mode", int'(mode), 0);

        pulse_pu();
        wait_tick(c);
        wait_tick(c);
        chk("ext_tick2_mode", int'(mode), 1);
        pulse_pu();
        chk("ext_reload_mode", int'(mode), 1);
        wait_tick(c);
        wait_tick(c);
        chk("ext_tick2_after_reload", int'(mode), 1);
        wait_tick(c);
        chk("ext_tick3_after_reload", int'(mode), 0);

        pulse_pu();
        wait_tick(c);
        wait_tick(c);
        repeat (3) @(negedge clk_run);
        pulse_pu();
        chk("expiry_pu_tick_aligned", int'(mt), 1);
        chk("expiry_pu_mode", int'(mode), 1);
        wait_tick(c);
        wait_tick(c);
        chk("expiry_pu_tick2_mode", int'(mode), 1);
        wait_tick(c);
        chk("expiry_pu_tick3_mode", int'(mode), 0);

        en = 1'b0;
        right = 1'b1;
        repeat (3) @(negedge clk_run);
        en = 1'b1;
        wait_tick(c);
        wait_tick(c);
        right = 1'b0;
        chk("pre_hit_x", int'(x), 273);
        hit = 1'b1;
        pu = 1'b1;
        @(negedge clk_run);
        hit = 1'b0;
        pu = 1'b0;
        chk("hit_pu_mode", int'(mode), 0);
        chk("hit_pu_x", int'(x), 269);
        chk("hit_pu_y", int'(y), 340);
        pulse_pu();
        chk("dbl_before_hit", int'(mode), 1);
        hit = 1'b1;
        @(negedge clk_run);
        hit = 1'b0;
        chk("hit_in_double_mode", int'(mode), 0);

        en = 1'b0;
        right = 1'b1;
        pulse_pu();
        chk("frozen_pu_mode", int'(mode), 1);
        repeat (2) @(negedge clk_run);
        en = 1'b1;
        wait_tick(c);
        chk("frz_pre_x", int'(x), 271);
        repeat (2) @(negedge clk_run);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_run);
            chk("frz_x", int'(x), 271);
            chk("frz_tick", int'(mt), 0);
        end
        chk("frz_mode", int'(mode), 1);
        en = 1'b1;
        wait_tick(c);
        chk("resume_latency", c, 2);
        chk("resume_x", int'(x), 273);
        chk("resume_mode", int'(mode), 1);
        wait_tick(c);
        chk("resume_tick2_x", int'(x), 275);
        chk("resume_tick2_mode", int'(mode), 0);
        right = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/me_plane_ctrl.md
# me_plane_ctrl

Player-plane controller upstream of `bullet`. It turns synchronized push-button levels into the player position pair `me_x_pos_o`/`me_y_pos_o`, clamped to the visible area, and drives the fire mode `mode_o` from a power-up timer. `bullet` consumes all three outputs directly. The block runs entirely in the `clk_run` domain.

## Interface
- `H_DISP`, 640: visible width in pixels.
- `V_DISP`, 480: visible height in pixels.
- `PLANE_W`, 102: plane sprite width.
- `PLANE_H`, 126: plane sprite height.
- `START_X`, 269: reset and respawn x.
- `START_Y`, 340: reset and respawn y.
- `STEP`, 2: pixels moved per move tick.
- `MOVE_DIV`, 2_000_000: `clk_run` cycles per move tick (8 ms at 250 MHz).
- `DOUBLE_TICKS`, 1250: move ticks that double mode lasts (10 s).
- `clk_run` input 1: system clock, 250 MHz.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_up_i`, `btn_down_i`, `btn_left_i`, `btn_right_i` input 1 each: debounced, asynchronous button levels, active-high.
- `game_en_i` input 1: level; 0 freezes the block.
- `powerup_i` input 1: one-cycle pulse when a power-up is collected.
- `hit_i` input 1: one-cycle pulse when the player plane is hit.
- `me_x_pos_o` output `OBJ_X_POS_BIT_LEN`: plane left edge.
- `me_y_pos_o` output `OBJ_Y_POS_BIT_LEN`: plane top edge.
- `mode_o` output 1: `BULLET_MODE_SINGLE` (0) or double (1).
- `move_tick_o` output 1: one-cycle pulse on each move tick.

## Operation
- **Button sync.** Each button passes through a 2-flop synchronizer. Only synchronized values are used.
- **Tick counter.**
  - `div_cnt` counts 0..`MOVE_DIV`-1 while `game_en_i`=1, then wraps to 0.
  - Tick is asserted in the cycle where `div_cnt`==`MOVE_DIV`-1.
  - When `game_en_i`=0, `div_cnt` holds and no tick is generated.
- **Movement.** On a tick, x and y update independently.
  - up&&!down: y -= `STEP`; down&&!up: y += `STEP`. left/right act the same way on x.
  - Both directions of an axis pressed, or neither pressed: that axis holds.
- **Clamping.**
  - Lower bound: if the subtraction would go below 0 (pos < `STEP`), the result is 0. Compare before subtracting; never wrap.
  - Upper bound: the result is capped at `H_DISP`-`PLANE_W` for x and `V_DISP`-`PLANE_H` for y.
  - Compute in width+1 bits so the sum cannot overflow.
- **Mode FSM.** States are SINGLE and DOUBLE.
  - SINGLE → DOUBLE on `powerup_i`: load `dbl_cnt`=`DOUBLE_TICKS`.
  - In DOUBLE, `powerup_i` reloads `dbl_cnt` to `DOUBLE_TICKS`.
  - In DOUBLE, `dbl_cnt` decrements on each tick. When a tick arrives with `dbl_cnt`==1, go to SINGLE.
  - `hit_i` in any state → SINGLE, clear `dbl_cnt`, and set position to (`START_X`, `START_Y`).
- **Simultaneous events.**
  - `hit_i` has priority over `powerup_i` and over a tick in the same cycle.
  - `powerup_i` in the same cycle as the expiring tick: the reload wins and the state stays DOUBLE.
- **Freeze.** `game_en_i`=0 holds position and `dbl_cnt`. `powerup_i` and `hit_i` are still honored.

## Timing
- **Reset values:** x=`START_X`, y=`START_Y`, `mode_o`=0, `move_tick_o`=0, `div_cnt`=0, `dbl_cnt`=0, synchronizers 0.
- **Reset mid-operation:** all state returns to the reset values asynchronously. The first tick occurs `MOVE_DIV` cycles after reset release with `game_en_i`=1.
- **Outputs:** all outputs are registered.
  - Position changes in the cycle after the tick cycle; `move_tick_o` is high in that same cycle.
  - Button-to-effect latency is 2 sync cycles plus waiting for the next tick.
- **Pulse inputs:** `powerup_i` and `hit_i` take effect on `mode_o` and position in the next cycle.
- **Stability:** `mode_o` changes at most once per cycle and is stable between events, so `bullet` can sample it at shoot time.

## Structure
- **`define.v`:**
  - New: `ME_START_X`, `ME_START_Y`, `ME_STEP`, `CNT_MAX_MOVE`, `DOUBLE_TICKS`.
  - Reuse: `OBJ_X_POS_BIT_LEN`, `OBJ_Y_POS_BIT_LEN`, `BULLET_MODE_SINGLE`, `BULLET_MODE_DOUBLE`.
- **Sub-module `axis_step`:** one instance per axis.
  - Parameters: `MAX`, `STEP`.
  - Inputs: pos, dec, inc, tick. Output: next pos with clamping.
- **Synchronizers:** instantiated inline.

## Test plan
Benches use `MOVE_DIV`=4, `STEP`=2, `DOUBLE_TICKS`=3 and the default screen and plane sizes.
- **Reset:** assert `rst` mid-run → next cycle x=269, y=340, `mode_o`=0. After release, the first `move_tick_o` pulse arrives 4 cycles later.
- **Right clamp:** hold right from x=536 → 538 → 538, x never exceeds 538. Left from x=1 → 0, no wrap to 1023.
- **Opposing buttons:** press up and down together for 10 ticks → y constant. Left alone → x decreases by 2 per tick.
- **Power-up expiry:** `powerup_i` → `mode_o`=1 next cycle and stays 1 for 3 ticks, → 0 after the 3rd tick. A repeat `powerup_i` at tick 2 extends to 3 ticks from the reload.
- **Simultaneous pulses:** `hit_i` and `powerup_i` in the same cycle → `mode_o`=0, position (269,340). `powerup_i` on the expiry tick → `mode_o` stays 1.
- **Freeze:** `game_en_i`=0 for 20 cycles while holding right → x and `dbl_cnt` unchanged, `move_tick_o` stays low. Resume → first tick at the remaining count.
